// File: rtl/core_pkt_pkg.sv
// core_pkt_pkg: command codes, packet field layout, packer and FSM states shared by host initiator and core decoder.
package core_pkt_pkg;
  localparam logic [7:0] CMD_WR_IN  = 8'hFF;
  localparam logic [7:0] CMD_WR_W   = 8'hF0;
  localparam logic [7:0] CMD_RD_IN  = 8'h0F;
  localparam logic [7:0] CMD_RD_W   = 8'h00;
  localparam logic [7:0] CMD_RD_OUT = 8'hAA;
  localparam logic [7:0] CMD_MATMUL = 8'h01;
  localparam int CORE_MSB = 31;
  localparam int CORE_LSB = 26;
  localparam int CMD_MSB  = 25;
  localparam int CMD_LSB  = 18;
  localparam int ROW_MSB  = 17;
  localparam int ROW_LSB  = 16;
  localparam int COL_MSB  = 15;
  localparam int COL_LSB  = 8;
  localparam int VAL_MSB  = 7;
  localparam int VAL_LSB  = 0;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_POP, S_CAPTURE} state_t;
  function automatic logic [31:0] pkt_pack(input logic [5:0] core, input logic [7:0] cmd,
                                           input logic [1:0] row, input logic [1:0] col,
                                           input logic [7:0] value);
    logic [31:0] p;
    p = '0;
    p[CORE_MSB:CORE_LSB] = core;
    p[CMD_MSB:CMD_LSB]   = cmd;
    p[ROW_MSB:ROW_LSB]   = row;
    p[COL_MSB:COL_LSB]   = {6'd0, col};
    p[VAL_MSB:VAL_LSB]   = value;
    return p;
  endfunction
  function automatic logic cmd_is_read(input logic [7:0] cmd);
    return cmd == CMD_RD_IN || cmd == CMD_RD_W || cmd == CMD_RD_OUT;
  endfunction
endpackage

// File: rtl/core_pkt_initiator.sv
// core_pkt_initiator: packs one host command into a core packet, pushes it downstream, and pops the reply for reads.
// Optional reply timeout enabled by defining CORE_PKT_TIMEOUT_EN.
import core_pkt_pkg::*;
module core_pkt_initiator #(
  parameter logic [5:0] CORE_ID     = 6'd0,
  parameter int         TIMEOUT_W   = 16,
  parameter int         TIMEOUT_MAX = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_core_sel,
  input  logic [5:0]  req_core,
  input  logic [7:0]  req_cmd,
  input  logic [1:0]  req_row,
  input  logic [1:0]  req_col,
  input  logic [7:0]  req_value,
  output logic [31:0] pkt_dout,
  output logic        pkt_wr_en,
  input  logic        pkt_full,
  input  logic [7:0]  rsp_din,
  input  logic        rsp_empty,
  output logic        rsp_rd_en,
  input  logic        rsp_valid,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_timeout,
  output logic        busy,
  output logic [15:0] pkt_count
);
  state_t state, next;
  logic   is_read;
  logic   tmo_hit;
`ifdef CORE_PKT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  assign tmo_hit = state == S_WAIT_RSP && tmo_cnt == TIMEOUT_W'(TIMEOUT_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= state == S_WAIT_RSP ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  assign req_ready   = state == S_IDLE;
  assign busy        = state != S_IDLE;
  assign out_timeout = tmo_hit;
  always_comb begin
    next      = state;
    pkt_wr_en = 1'b0;
    rsp_rd_en = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:     next = req_valid ? S_SEND : S_IDLE;
      S_SEND: if (!pkt_full) begin
        pkt_wr_en = 1'b1;
        next      = is_read ? S_WAIT_RSP : S_IDLE;
      end
      S_WAIT_RSP: if (tmo_hit) begin
        out_valid = 1'b1;
        next      = S_IDLE;
      end else if (!rsp_empty) begin
        rsp_rd_en = 1'b1;
        next      = S_POP;
      end
      S_POP:      next = rsp_valid ? S_CAPTURE : S_POP;
      S_CAPTURE: begin
        out_valid = 1'b1;
        next      = S_IDLE;
      end
      default:    next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      pkt_dout  <= '0;
      is_read   <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && req_valid) begin
        pkt_dout <= pkt_pack(req_core_sel ? req_core : CORE_ID, req_cmd, req_row, req_col, req_value);
        is_read  <= cmd_is_read(req_cmd);
      end
      if (state == S_POP && rsp_valid) out_data <= rsp_din;
      if (pkt_wr_en) pkt_count <= pkt_count + 16'd1;
    end
endmodule
